// File: rtl/alarma_pkg.sv
// rtl/alarma_pkg.sv - state encodings and default timing constants for the alarm annunciator
package alarma_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SONANDO   = 2'd1,
        POSPUESTA = 2'd2
    } estado_t;

    localparam int T_SONAR_DEF      = 60;
    localparam int T_POSPONER_DEF   = 300;
    localparam int MAX_POSPONER_DEF = 3;
    localparam int HOLDOFF_DEF      = 2;
    localparam int CNT_W_DEF        = 10;

endpackage

// File: rtl/contador_segundos.sv
// rtl/contador_segundos.sv - tick-enabled saturating up-counter with sync clear and terminal strobe
module contador_segundos #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_terminal,
    output logic             o_expira
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cuenta;
    logic [CNT_W-1:0] w_cuenta_sig;
    logic             r_ultimo;

    always_comb begin
        w_cuenta_sig = r_cuenta;
        if (i_clr)
            w_cuenta_sig = '0;
        else if (i_tick && (r_cuenta != CNT_MAX))
            w_cuenta_sig = r_cuenta + 1'b1;
    end

    // r_ultimo marks "the next tick is the terminal one", so the strobe lands on that tick's cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cuenta <= '0;
            r_ultimo <= 1'b0;
        end else begin
            r_cuenta <= w_cuenta_sig;
            r_ultimo <= (w_cuenta_sig == (i_terminal - 1'b1));
        end
    end

    assign o_expira = r_ultimo & i_tick;

endmodule

// File: rtl/control_alarma.sv
// rtl/control_alarma.sv - alarm annunciator FSM; define ALARMA_PATRON_EN for 1 s on/off beep pattern
module control_alarma
    import alarma_pkg::*;
#(
    parameter int T_SONAR      = T_SONAR_DEF,
    parameter int T_POSPONER   = T_POSPONER_DEF,
    parameter int MAX_POSPONER = MAX_POSPONER_DEF,
    parameter int HOLDOFF      = HOLDOFF_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] alarma,
    input  logic       tick_1hz,
    input  logic       btn_apagar,
    input  logic       btn_posponer,
    output logic       rst_alarma,
    output logic       buzzer,
    output logic       led_alerta,
    output logic [1:0] estado,
    output logic [1:0] num_pospuestas
);

    localparam logic [CNT_W-1:0] T_SON_V  = CNT_W'(T_SONAR);
    localparam logic [CNT_W-1:0] T_POS_V  = CNT_W'(T_POSPONER);
    localparam logic [CNT_W-1:0] HOLD_V   = CNT_W'(HOLDOFF);
    localparam logic [1:0]       MAX_P_V  = 2'(MAX_POSPONER);

    estado_t          r_estado, w_estado_sig;
    logic [CNT_W-1:0] r_holdoff, w_holdoff_sig;
    logic [1:0]       r_num, w_num_sig;
    logic             r_rst_alarma, r_buzzer, r_led;
    logic             w_buzzer_sig, w_led_sig, w_pulso, w_clr, w_expira;
    logic [CNT_W-1:0] w_terminal;

    assign w_terminal = (w_estado_sig == POSPUESTA) ? T_POS_V : T_SON_V;

    contador_segundos #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_tick     (tick_1hz),
        .i_terminal (w_terminal),
        .o_expira   (w_expira)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado     <= IDLE;
            r_holdoff    <= '0;
            r_num        <= '0;
            r_rst_alarma <= 1'b0;
            r_buzzer     <= 1'b0;
            r_led        <= 1'b0;
        end else begin
            r_estado     <= w_estado_sig;
            r_holdoff    <= w_holdoff_sig;
            r_num        <= w_num_sig;
            r_rst_alarma <= w_pulso & ~r_rst_alarma;
            r_buzzer     <= w_buzzer_sig;
            r_led        <= w_led_sig;
        end
    end

    // Buttons are checked before the timer strobe so they win over a coincident timeout
    always_comb begin
        w_estado_sig  = r_estado;
        w_holdoff_sig = r_holdoff;
        w_num_sig     = r_num;
        w_pulso       = 1'b0;
        w_clr         = 1'b0;
        case (r_estado)
            IDLE: begin
                w_clr = 1'b1;
                if (r_holdoff != '0) begin
                    if (tick_1hz)
                        w_holdoff_sig = r_holdoff - 1'b1;
                end else if (alarma != 4'd0) begin
                    w_estado_sig = SONANDO;
                    w_num_sig    = 2'd0;
                end
            end
            SONANDO: begin
                if (btn_apagar || (btn_posponer && (r_num >= MAX_P_V))) begin
                    w_estado_sig  = IDLE;
                    w_holdoff_sig = HOLD_V;
                    w_pulso       = 1'b1;
                    w_clr         = 1'b1;
                end else if (btn_posponer) begin
                    w_estado_sig = POSPUESTA;
                    w_num_sig    = r_num + 2'd1;
                    w_pulso      = 1'b1;
                    w_clr        = 1'b1;
                end else if (w_expira) begin
                    w_estado_sig  = IDLE;
                    w_holdoff_sig = HOLD_V;
                    w_pulso       = 1'b1;
                    w_clr         = 1'b1;
                end
            end
            POSPUESTA: begin
                if (btn_apagar) begin
                    w_estado_sig  = IDLE;
                    w_holdoff_sig = HOLD_V;
                    w_pulso       = 1'b1;
                    w_clr         = 1'b1;
                end else if (w_expira) begin
                    w_estado_sig = SONANDO;
                    w_clr        = 1'b1;
                end
            end
            default: begin
                w_estado_sig = IDLE;
                w_clr        = 1'b1;
            end
        endcase
    end

`ifdef ALARMA_PATRON_EN
    always_comb begin
        w_buzzer_sig = 1'b0;
        w_led_sig    = (w_estado_sig == POSPUESTA);
        if (w_estado_sig == SONANDO) begin
            if (r_estado != SONANDO)
                w_buzzer_sig = 1'b1;
            else
                w_buzzer_sig = tick_1hz ? ~r_buzzer : r_buzzer;
            w_led_sig = w_buzzer_sig;
        end
    end
`else
    always_comb begin
        w_buzzer_sig = (w_estado_sig == SONANDO);
        w_led_sig    = (w_estado_sig != IDLE);
    end
`endif

    assign rst_alarma     = r_rst_alarma;
    assign buzzer         = r_buzzer;
    assign led_alerta     = r_led;
    assign estado         = r_estado;
    assign num_pospuestas = r_num;

endmodule

// File: tb/tb_control_alarma.sv
// tb/tb_control_alarma.sv - directed self-checking bench for control_alarma
module tb_control_alarma;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] alarma = 4'd0;
    logic       tick_1hz = 1'b0;
    logic       btn_apagar = 1'b0;
    logic       btn_posponer = 1'b0;
    logic       rst_alarma, buzzer, led_alerta;
    logic [1:0] estado, num_pospuestas;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_alarma #(
        .T_SONAR      (4),
        .T_POSPONER   (3),
        .MAX_POSPONER (2),
        .HOLDOFF      (2),
        .CNT_W        (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alarma         (alarma),
        .tick_1hz       (tick_1hz),
        .btn_apagar     (btn_apagar),
        .btn_posponer   (btn_posponer),
        .rst_alarma     (rst_alarma),
        .buzzer         (buzzer),
        .led_alerta     (led_alerta),
        .estado         (estado),
        .num_pospuestas (num_pospuestas)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
    endtask

    task automatic entrar(input logic [3:0] v);
        alarma = v;
        cyc();
        alarma = 4'd0;
    endtask

    initial begin
        repeat (2) cyc();
        check("rst_estado", 32'(estado), 0);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_led", 32'(led_alerta), 0);
        check("rst_pulse", 32'(rst_alarma), 0);
        check("rst_num", 32'(num_pospuestas), 0);
        reset = 1'b1;
        cyc();

        // ring and time out after exactly 4 ticks
        entrar(4'd1);
        check("t1_estado_in", 32'(estado), 1);
        check("t1_buzzer_in", 32'(buzzer), 1);
        check("t1_led_in", 32'(led_alerta), 1);
        tick();
`ifdef ALARMA_PATRON_EN
        check("pat_buzzer_t1", 32'(buzzer), 0);
        check("pat_led_t1", 32'(led_alerta), 0);
        tick();
        check("pat_buzzer_t2", 32'(buzzer), 1);
`else
        check("t1_buzzer_steady", 32'(buzzer), 1);
        check("t1_led_steady", 32'(led_alerta), 1);
        tick();
`endif
        tick();
        check("t1_estado_3t", 32'(estado), 1);
        check("t1_pulse_none", 32'(rst_alarma), 0);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("t1_estado_out", 32'(estado), 0);
        check("t1_pulse", 32'(rst_alarma), 1);
        check("t1_buzzer_out", 32'(buzzer), 0);
        cyc();
        check("t1_pulse_one", 32'(rst_alarma), 0);
        tick();
        tick();

        // snooze and return to ringing after 3 ticks
        entrar(4'h8);
        check("t2_estado_in", 32'(estado), 1);
        check("t2_num0", 32'(num_pospuestas), 0);
        btn_posponer = 1'b1;
        cyc();
        btn_posponer = 1'b0;
        check("t2_pulse", 32'(rst_alarma), 1);
        check("t2_estado_pos", 32'(estado), 2);
        check("t2_num1", 32'(num_pospuestas), 1);
        check("t2_buzzer_pos", 32'(buzzer), 0);
        check("t2_led_pos", 32'(led_alerta), 1);
        cyc();
        check("t2_pulse_one", 32'(rst_alarma), 0);
        tick();
        tick();
        check("t2_estado_2t", 32'(estado), 2);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("t2_estado_back", 32'(estado), 1);
        check("t2_buzzer_back", 32'(buzzer), 1);
        check("t2_no_pulse", 32'(rst_alarma), 0);

        // second snooze, then third press acts as off
        btn_posponer = 1'b1;
        cyc();
        btn_posponer = 1'b0;
        check("t3_num2", 32'(num_pospuestas), 2);
        check("t3_estado_pos", 32'(estado), 2);
        tick();
        tick();
        tick();
        check("t3_estado_back", 32'(estado), 1);
        btn_posponer = 1'b1;
        cyc();
        btn_posponer = 1'b0;
        check("t3_estado_off", 32'(estado), 0);
        check("t3_pulse", 32'(rst_alarma), 1);
        check("t3_num_sat", 32'(num_pospuestas), 2);
        cyc();
        check("t3_pulse_one", 32'(rst_alarma), 0);
        tick();
        tick();

        // off and snooze together
        entrar(4'h3);
        check("t4_num_reset", 32'(num_pospuestas), 0);
        btn_apagar = 1'b1;
        btn_posponer = 1'b1;
        cyc();
        btn_apagar = 1'b0;
        btn_posponer = 1'b0;
        check("t4_estado", 32'(estado), 0);
        check("t4_pulse", 32'(rst_alarma), 1);
        check("t4_num", 32'(num_pospuestas), 0);
        cyc();
        check("t4_pulse_one", 32'(rst_alarma), 0);

        // holdoff with alarm held high
        alarma = 4'd1;
        cyc();
        check("t5_hold_a", 32'(estado), 0);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
        check("t5_hold_b", 32'(estado), 0);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("t5_hold_c", 32'(estado), 0);
        cyc();
        check("t5_reenter", 32'(estado), 1);
        alarma = 4'd0;

        // snooze press coinciding with the timeout tick still snoozes
        tick();
        tick();
        tick();
        tick_1hz = 1'b1;
        btn_posponer = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        btn_posponer = 1'b0;
        check("t6_estado", 32'(estado), 2);
        check("t6_num", 32'(num_pospuestas), 1);
        cyc();
        btn_posponer = 1'b1;
        cyc();
        btn_posponer = 1'b0;
        check("t6_pos_ignored", 32'(estado), 2);
        check("t6_pos_nopulse", 32'(rst_alarma), 0);
        btn_apagar = 1'b1;
        cyc();
        btn_apagar = 1'b0;
        check("t6_off_estado", 32'(estado), 0);
        check("t6_off_pulse", 32'(rst_alarma), 1);
        cyc();
        tick();
        tick();

        // asynchronous reset mid-ring
        entrar(4'd2);
        check("t7_estado_in", 32'(estado), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t7_estado", 32'(estado), 0);
        check("t7_buzzer", 32'(buzzer), 0);
        check("t7_led", 32'(led_alerta), 0);
        check("t7_pulse", 32'(rst_alarma), 0);
        check("t7_num", 32'(num_pospuestas), 0);
        cyc();
        reset = 1'b1;
        cyc();
        check("t7_after_pulse", 32'(rst_alarma), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
